// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmitter and receiver.
//   tx_state_t       - transmitter frame state
//   uart_frame_cfg_t - per-frame line format (parity, data length, stop bits)
//   UART_DATA_W      - width of the parallel data word
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  typedef struct packed {
    logic parity_enable;  // append a parity bit after the data bits
    logic parity_odd;     // 1 = odd parity, 0 = even parity
    logic data_len_7bit;  // 1 = 7 data bits, 0 = 8 data bits
    logic stop_2;         // 1 = two stop bits
  } uart_frame_cfg_t;

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte stream into the UART transmitter.
//   tx_data  - byte to send (source -> transmitter)
//   tx_valid - tx_data valid (source -> transmitter)
//   tx_ready - transmitter can accept a byte (transmitter -> source)
// Modports: master = byte source (register/FIFO front end), slave = uart_tx.
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] tx_data;
  logic                   tx_valid;
  logic                   tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Serialises bytes onto txd as
//   start / data (LSB first) / optional parity / one or two stop bits.
// Bit timing: osr_value oversample ticks per bit (0 means 2**OSR_W).
// A one-entry holding register lets frames go out back-to-back with no gap.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   enable         - global UART enable
//   tx_enable      - transmitter enable
//   parity_enable, parity_odd, data_len_7bit, stop_2 - frame format,
//                    latched when a byte moves into the shift register
//   osr_tick       - one-cycle oversample strobe
//   osr_value      - ticks per bit
//   tx_if          - valid/ready byte stream (slave side)
//   txd            - serial line, idle high (registered)
//   tx_done        - one-cycle pulse on the cycle the last stop bit ends
//   busy           - frame in progress or holding register full
module uart_tx
  import uart_pkg::*;
#(
  parameter int OSR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             tx_enable,
  input  logic             parity_enable,
  input  logic             parity_odd,
  input  logic             data_len_7bit,
  input  logic             stop_2,
  input  logic             osr_tick,
  input  logic [OSR_W-1:0] osr_value,
  uart_tx_if.slave         tx_if,
  output logic             txd,
  output logic             tx_done,
  output logic             busy
);

  tx_state_t              state_q, state_d;
  logic [OSR_W-1:0]       phase_q, phase_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   par_acc_q, par_acc_d;
  uart_frame_cfg_t        cfg_q, cfg_d;
  logic [UART_DATA_W-1:0] hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic                   txd_q, txd_d;

  logic                   en;
  logic                   xfer;
  logic                   bit_end;
  logic                   load;
  logic                   frame_end;
  logic [2:0]             last_idx;

  assign en = enable & tx_enable;

  assign tx_if.tx_ready = en & ~hold_full_q & ~rst;
  assign xfer           = tx_if.tx_valid & tx_if.tx_ready;

  // The subtraction is kept at OSR_W bits, so osr_value = 0 compares
  // against all-ones and a bit lasts 2**OSR_W ticks.
  assign bit_end = osr_tick && (phase_q == (osr_value - OSR_W'(1)));

  assign last_idx = cfg_q.data_len_7bit ? 3'd6 : 3'd7;

  assign txd  = txd_q;
  assign busy = (state_q != IDLE) | hold_full_q;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      bit_idx_q   <= '0;
      stop_cnt_q  <= 1'b0;
      shift_q     <= '0;
      par_acc_q   <= 1'b0;
      cfg_q       <= '0;
      hold_full_q <= 1'b0;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_idx_q   <= bit_idx_d;
      stop_cnt_q  <= stop_cnt_d;
      shift_q     <= shift_d;
      par_acc_q   <= par_acc_d;
      cfg_q       <= cfg_d;
      hold_full_q <= hold_full_d;
      txd_q       <= txd_d;
    end
  end

  // NOTE: the holding data is not reset; hold_full_q alone says whether it
  // holds anything, so its contents are never observed while stale.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_idx_d   = bit_idx_q;
    stop_cnt_d  = stop_cnt_q;
    shift_d     = shift_q;
    par_acc_d   = par_acc_q;
    cfg_d       = cfg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;
    frame_end   = 1'b0;

    if (!en) begin
      // Disable truncates the frame and drops any queued byte.
      state_d     = IDLE;
      phase_d     = '0;
      bit_idx_d   = '0;
      stop_cnt_d  = 1'b0;
      par_acc_d   = 1'b0;
      hold_full_d = 1'b0;
    end else begin
      if (state_q != IDLE && osr_tick) begin
        phase_d = bit_end ? '0 : phase_q + OSR_W'(1);
      end

      unique case (state_q)
        IDLE: load = hold_full_q;
        START: begin
          if (bit_end) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            par_acc_d = par_acc_q ^ shift_q[bit_idx_q];
            if (bit_idx_q == last_idx) begin
              state_d    = cfg_q.parity_enable ? PARITY : STOP;
              stop_cnt_d = 1'b0;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_d    = STOP;
            stop_cnt_d = 1'b0;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop_cnt_q == cfg_q.stop_2) begin
              frame_end = 1'b1;
              if (hold_full_q) load = 1'b1;
              else             state_d = IDLE;
            end else begin
              stop_cnt_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (load) begin
        state_d     = START;
        shift_d     = hold_q;
        cfg_d       = '{parity_enable: parity_enable, parity_odd: parity_odd,
                        data_len_7bit: data_len_7bit, stop_2: stop_2};
        hold_full_d = 1'b0;
        phase_d     = '0;
        bit_idx_d   = '0;
        stop_cnt_d  = 1'b0;
        par_acc_d   = 1'b0;
      end

      if (xfer) begin
        hold_d      = tx_if.tx_data;
        hold_full_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: txd is registered from the next state so the line changes
  // exactly on the edge that enters a bit.
  // ---------------------------------------------------------------------
  always_comb begin
    txd_d   = 1'b1;
    tx_done = frame_end & ~rst;
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[bit_idx_d];
      PARITY:  txd_d = par_acc_d ^ cfg_d.parity_odd;
      default: txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       tx_enable;
  logic       parity_enable;
  logic       parity_odd;
  logic       data_len_7bit;
  logic       stop_2;
  logic       osr_tick = 1'b1;
  logic [7:0] osr_value;
  logic       txd;
  logic       tx_done;
  logic       busy;

  int total = 0;
  int bad   = 0;

  int tick_div = 1;
  int tick_cnt = 0;

  uart_tx_if bus ();

  uart_tx #(.OSR_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .tx_enable     (tx_enable),
    .parity_enable (parity_enable),
    .parity_odd    (parity_odd),
    .data_len_7bit (data_len_7bit),
    .stop_2        (stop_2),
    .osr_tick      (osr_tick),
    .osr_value     (osr_value),
    .tx_if         (bus.slave),
    .txd           (txd),
    .tx_done       (tx_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Oversample strobe: one cycle in every tick_div.
  always @(negedge clk) begin
    tick_cnt = (tick_cnt + 1) % tick_div;
    osr_tick = (tick_cnt == 0);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte and hold it until accepted; returns one negedge later.
  task automatic send(input logic [7:0] b);
    int n = 0;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    while (bus.tx_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", {31'd0, bus.tx_ready}, 32'd1);
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (txd !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start"}, {31'd0, txd}, 32'd0);
  endtask

  // Expected frame is a string of '0'/'1', first bit on the line first.
  // Each bit is checked on its first and last cycle; tx_done must pulse
  // exactly once, on the last cycle of the frame.
  task automatic check_frame(input string tag, input string bits, input int bc, input bit contig);
    int nb = bits.len();
    int done_cnt = 0;
    if (contig) @(negedge clk);
    else        wait_start(tag);
    for (int t = 0; t < nb * bc; t++) begin
      if (t > 0) @(negedge clk);
      if (tx_done === 1'b1) done_cnt++;
      if ((t % bc) == 0 || (t % bc) == bc - 1)
        check($sformatf("%s_bit%0d_c%0d", tag, t / bc, t % bc), {31'd0, txd},
              {31'd0, bits[t / bc] == "1"});
    end
    check({tag, "_done_last"}, {31'd0, tx_done}, 32'd1);
    check({tag, "_done_cnt"}, done_cnt, 32'd1);
  endtask

  initial begin
    int cnt_done;
    int cnt_low;

    rst           = 1'b1;
    enable        = 1'b1;
    tx_enable     = 1'b1;
    parity_enable = 1'b0;
    parity_odd    = 1'b0;
    data_len_7bit = 1'b0;
    stop_2        = 1'b0;
    osr_value     = 8'd16;
    bus.tx_data   = 8'h00;
    bus.tx_valid  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_ready", {31'd0, bus.tx_ready}, 32'd0);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, bus.tx_ready}, 32'd1);

    // 1. 8N1, 0xA5
    send(8'hA5);
    check_frame("t1_a5", "0101001011", 16, 1'b0);
    check("t1_busy_last", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("t1_busy_after", {31'd0, busy}, 32'd0);
    check("t1_done_after", {31'd0, tx_done}, 32'd0);
    check("t1_txd_idle", {31'd0, txd}, 32'd1);

    // 2. 7E2, 0x53 and 0xD3 give the same waveform
    parity_enable = 1'b1; parity_odd = 1'b0; data_len_7bit = 1'b1; stop_2 = 1'b1;
    @(negedge clk);
    send(8'h53);
    check_frame("t2_53", "01100101011", 16, 1'b0);
    @(negedge clk);
    send(8'hD3);
    check_frame("t2_d3", "01100101011", 16, 1'b0);
    @(negedge clk);

    // 3. Parity corner cases
    parity_enable = 1'b1; parity_odd = 1'b1; data_len_7bit = 1'b0; stop_2 = 1'b0;
    send(8'h00);
    check_frame("t3_8o1_00", "00000000011", 16, 1'b0);
    @(negedge clk);
    send(8'hFF);
    check_frame("t3_8o1_ff", "01111111111", 16, 1'b0);
    @(negedge clk);
    parity_odd = 1'b0;
    send(8'hFF);
    check_frame("t3_8e1_ff", "01111111101", 16, 1'b0);
    @(negedge clk);

    // 4. Back-to-back frames with tx_valid held
    parity_enable = 1'b0; parity_odd = 1'b0; data_len_7bit = 1'b0; stop_2 = 1'b0;
    @(negedge clk);
    fork
      begin
        logic [7:0] vals [3];
        vals = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
          int n = 0;
          bus.tx_data  = vals[i];
          bus.tx_valid = 1'b1;
          while (bus.tx_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
          end
          check($sformatf("t4_accept%0d", i), {31'd0, bus.tx_ready}, 32'd1);
          @(negedge clk);
          check($sformatf("t4_ready_low%0d", i), {31'd0, bus.tx_ready}, 32'd0);
        end
        bus.tx_valid = 1'b0;
      end
      begin
        check_frame("t4_11", "0100010001", 16, 1'b0);
        check_frame("t4_22", "0010001001", 16, 1'b1);
        check_frame("t4_33", "0110011001", 16, 1'b1);
      end
    join
    @(negedge clk);
    check("t4_busy_after", {31'd0, busy}, 32'd0);

    // 5. Disable in DATA bit 3 with a byte queued, then re-enable
    @(negedge clk);
    send(8'hA5);
    wait_start("t5");
    send(8'h3C);
    repeat (68) @(negedge clk);
    check("t5_txd_bit3", {31'd0, txd}, 32'd0);
    check("t5_busy_before", {31'd0, busy}, 32'd1);
    tx_enable = 1'b0;
    @(negedge clk);
    check("t5_txd_dis", {31'd0, txd}, 32'd1);
    check("t5_busy_dis", {31'd0, busy}, 32'd0);
    check("t5_done_dis", {31'd0, tx_done}, 32'd0);
    check("t5_ready_dis", {31'd0, bus.tx_ready}, 32'd0);
    cnt_done = 0;
    cnt_low  = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) cnt_done++;
      if (txd !== 1'b1) cnt_low++;
    end
    check("t5_no_done", cnt_done, 32'd0);
    check("t5_line_idle", cnt_low, 32'd0);
    tx_enable = 1'b1;
    #1;
    check("t5_ready_reen", {31'd0, bus.tx_ready}, 32'd1);
    check("t5_busy_reen", {31'd0, busy}, 32'd0);
    cnt_low = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) cnt_low++;
    end
    check("t5_no_resume", cnt_low, 32'd0);
    send(8'h5A);
    check_frame("t5_5a", "0010110101", 16, 1'b0);
    @(negedge clk);

    // 6. osr_value = 0 (256 ticks/bit), tick every 4th cycle, reset mid-frame
    osr_value = 8'd0;
    tick_div  = 4;
    @(negedge clk);
    send(8'h01);
    wait_start("t6");
    repeat (1020) @(negedge clk);
    check("t6_start_late", {31'd0, txd}, 32'd0);
    repeat (5) @(negedge clk);
    check("t6_bit0_early", {31'd0, txd}, 32'd1);
    repeat (1015) @(negedge clk);
    check("t6_bit0_late", {31'd0, txd}, 32'd1);
    repeat (10) @(negedge clk);
    check("t6_bit1_early", {31'd0, txd}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_txd", {31'd0, txd}, 32'd1);
    check("t6_rst_ready", {31'd0, bus.tx_ready}, 32'd0);
    check("t6_rst_done", {31'd0, tx_done}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t6_ready_after", {31'd0, bus.tx_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
